// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file for the multicycle datapath.
//
// Purpose:
//   Holds NUM_REGS x DATA_W registers. It has two registered read ports (the A/B operand
//   latches), one general write port and a dedicated link-register write port. A
//   per-register pending scoreboard lets the control FSM stall on registers that are
//   waiting for a multicycle result. The hardwired zero register and write-to-read
//   bypass are selected by parameters.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   rs, rt               read addresses for port A / port B
//   rd_en                capture value(rs)/value(rt) into out_data_a/out_data_b
//   rd, we, i_data       general write port
//   link_we, link_data   link write port (always targets LINK_REG)
//   pend_set, pend_addr  mark a register as awaiting a result
//   out_data_a/b         registered read data
//   busy_a/b             combinational pending[rs] / pending[rt]
module regfile_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic              we,
    input  logic [DATA_W-1:0] i_data,
    input  logic              link_we,
    input  logic [DATA_W-1:0] link_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]   out_a_q, out_b_q;
    logic [DATA_W-1:0]   val_a, val_b;

    logic gen_wr, link_wr, pend_wr;

    // Effective write strobes after zero-register masking and collision resolution.
    // The link port yields whenever the general port targets the link register.
    always_comb begin
        gen_wr  = we && !((ZERO_REG != 0) && (rd == '0));
        link_wr = link_we && !((ZERO_REG != 0) && (LinkAddr == '0))
                  && !(we && (rd == LinkAddr));
        pend_wr = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));
    end

    // Read values presented to the capture latches.
    always_comb begin
        val_a = regs_q[rs];
        val_b = regs_q[rt];
        if (BYPASS != 0) begin
            if (gen_wr && (rd == rs)) begin
                val_a = i_data;
            end else if (link_wr && (LinkAddr == rs)) begin
                val_a = link_data;
            end
            if (gen_wr && (rd == rt)) begin
                val_b = i_data;
            end else if (link_wr && (LinkAddr == rt)) begin
                val_b = link_data;
            end
        end
        if ((ZERO_REG != 0) && (rs == '0)) begin
            val_a = '0;
        end
        if ((ZERO_REG != 0) && (rt == '0)) begin
            val_b = '0;
        end
    end

    // Scoreboard next state: writes retire the pending bit; a new pend_set applied
    // afterwards wins, because it marks a freshly issued producer.
    always_comb begin
        pend_d = pend_q;
        if (gen_wr) begin
            pend_d[rd] = 1'b0;
        end
        if (link_wr) begin
            pend_d[LinkAddr] = 1'b0;
        end
        if (pend_wr) begin
            pend_d[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (gen_wr) begin
                regs_q[rd] <= i_data;
            end
            if (link_wr) begin
                regs_q[LinkAddr] <= link_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (rd_en) begin
                out_a_q <= val_a;
                out_b_q <= val_b;
            end
        end
    end

    always_comb begin
        out_data_a = out_a_q;
        out_data_b = out_b_q;
        busy_a     = pend_q[rs];
        busy_b     = pend_q[rt];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: self-checking bench for regfile_multiport (default parameters:
// 32x32, ZERO_REG=1, LINK_REG=31, BYPASS=1), with directed scenarios and a random run
// compared against an array-based reference model.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs, rt, rd, pend_addr;
    logic        rd_en, we, link_we, pend_set;
    logic [31:0] i_data, link_data;
    logic [31:0] out_data_a, out_data_b;
    logic        busy_a, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_pend [32];
    logic [31:0] m_a, m_b;

    regfile_multiport dut (
        .clk        (clk),
        .rst        (rst),
        .rs         (rs),
        .rt         (rt),
        .rd_en      (rd_en),
        .rd         (rd),
        .we         (we),
        .i_data     (i_data),
        .link_we    (link_we),
        .link_data  (link_data),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mval(input logic [4:0] x);
        if (x == 5'd0) return 32'h0;
        if (we && rd == x) return i_data;
        if (link_we && x == 5'd31) return link_data;
        return m_regs[x];
    endfunction

    task automatic idle();
        rst = 0; rd_en = 0; we = 0; link_we = 0; pend_set = 0;
        rs = 0; rt = 0; rd = 0; pend_addr = 0; i_data = 0; link_data = 0;
    endtask

    // Apply one clock edge with the currently driven inputs and advance the model.
    task automatic cycle();
        logic [31:0] va, vb;
        va = mval(rs);
        vb = mval(rt);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_pend[i] = 0;
            end
            m_a = 0;
            m_b = 0;
        end else begin
            if (rd_en) begin
                m_a = va;
                m_b = vb;
            end
            if (we && rd != 0) begin
                m_regs[rd] = i_data;
                m_pend[rd] = 0;
            end
            if (link_we && !(we && rd == 5'd31)) begin
                m_regs[31] = link_data;
                m_pend[31] = 0;
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1; rd = a; i_data = d; cycle(); idle();
    endtask

    task automatic read_regs(input logic [4:0] a, input logic [4:0] b);
        idle(); rd_en = 1; rs = a; rt = b; cycle(); idle();
    endtask

    task automatic test_reset();
        write_reg(5'd5, 32'hDEADBEEF);
        read_regs(5'd5, 5'd5);
        idle(); pend_set = 1; pend_addr = 5'd12; cycle();
        idle(); rst = 1; we = 1; rd = 5'd5; i_data = 32'h11111111; rd_en = 1; rs = 5'd5;
        rt = 5'd5; pend_set = 1; pend_addr = 5'd6; cycle(); idle();
        n_checks++;
        if (out_data_a !== 32'h0) $display("FAIL reset_out_a got %h exp %h", out_data_a, 32'h0);
        else n_pass++;
        n_checks++;
        if (out_data_b !== 32'h0) $display("FAIL reset_out_b got %h exp %h", out_data_b, 32'h0);
        else n_pass++;
        read_regs(5'd5, 5'd12);
        n_checks++;
        if (out_data_a !== 32'h0) $display("FAIL reset_r5 got %h exp %h", out_data_a, 32'h0);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i); #1;
            n_checks++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0)
                $display("FAIL reset_busy r%0d got %b%b exp 00", i, busy_a, busy_b);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_write_read();
        write_reg(5'd7, 32'h12345678);
        write_reg(5'd8, 32'hCAFEF00D);
        read_regs(5'd7, 5'd8);
        n_checks++;
        if (out_data_a !== 32'h12345678) $display("FAIL wr_a got %h exp %h", out_data_a, 32'h12345678);
        else n_pass++;
        n_checks++;
        if (out_data_b !== 32'hCAFEF00D) $display("FAIL wr_b got %h exp %h", out_data_b, 32'hCAFEF00D);
        else n_pass++;
        idle(); rs = 5'd8; rt = 5'd7; we = 1; rd = 5'd7; i_data = 32'h0BADF00D; cycle(); idle();
        n_checks++;
        if (out_data_a !== 32'h12345678 || out_data_b !== 32'hCAFEF00D)
            $display("FAIL wr_hold got %h/%h exp %h/%h", out_data_a, out_data_b,
                     32'h12345678, 32'hCAFEF00D);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        idle(); we = 1; rd = 5'd0; i_data = 32'hFFFFFFFF; pend_set = 1; pend_addr = 5'd0;
        rd_en = 1; rs = 5'd0; rt = 5'd0; cycle(); idle();
        n_checks++;
        if (out_data_a !== 32'h0) $display("FAIL zero_bypass got %h exp %h", out_data_a, 32'h0);
        else n_pass++;
        read_regs(5'd0, 5'd0);
        n_checks++;
        if (out_data_a !== 32'h0) $display("FAIL zero_read got %h exp %h", out_data_a, 32'h0);
        else n_pass++;
        rs = 5'd0; #1;
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy_a);
        else n_pass++;
        idle();
    endtask

    task automatic test_bypass();
        write_reg(5'd3, 32'h33333333);
        idle(); we = 1; rd = 5'd3; i_data = 32'hA5A5A5A5; rd_en = 1; rs = 5'd3; rt = 5'd4;
        cycle(); idle();
        n_checks++;
        if (out_data_a !== 32'hA5A5A5A5) $display("FAIL bypass_a got %h exp %h", out_data_a, 32'hA5A5A5A5);
        else n_pass++;
        idle(); link_we = 1; link_data = 32'h5A5A5A5A; rd_en = 1; rs = 5'd3; rt = 5'd31;
        cycle(); idle();
        n_checks++;
        if (out_data_b !== 32'h5A5A5A5A) $display("FAIL bypass_link got %h exp %h", out_data_b, 32'h5A5A5A5A);
        else n_pass++;
    endtask

    task automatic test_link();
        idle(); we = 1; rd = 5'd31; i_data = 32'h1; link_we = 1; link_data = 32'h2;
        rd_en = 1; rs = 5'd31; rt = 5'd31; cycle(); idle();
        n_checks++;
        if (out_data_a !== 32'h1) $display("FAIL link_collide_bypass got %h exp %h", out_data_a, 32'h1);
        else n_pass++;
        read_regs(5'd31, 5'd0);
        n_checks++;
        if (out_data_a !== 32'h1) $display("FAIL link_collide got %h exp %h", out_data_a, 32'h1);
        else n_pass++;
        idle(); link_we = 1; link_data = 32'h2; cycle(); idle();
        read_regs(5'd0, 5'd31);
        n_checks++;
        if (out_data_b !== 32'h2) $display("FAIL link_alone got %h exp %h", out_data_b, 32'h2);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle(); pend_set = 1; pend_addr = 5'd9; cycle(); idle();
        rs = 5'd9; rt = 5'd10; #1;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b0) $display("FAIL sb_set got %b%b exp 10", busy_a, busy_b);
        else n_pass++;
        write_reg(5'd9, 32'h99);
        rs = 5'd9; #1;
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL sb_clear got %b exp 0", busy_a);
        else n_pass++;
        idle(); pend_set = 1; pend_addr = 5'd9; cycle();
        idle(); we = 1; rd = 5'd9; i_data = 32'h98; pend_set = 1; pend_addr = 5'd9; rs = 5'd9;
        #1;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL sb_no_early_clear got %b exp 1", busy_a);
        else n_pass++;
        cycle(); idle(); rs = 5'd9; rt = 5'd9; #1;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) $display("FAIL sb_set_wins got %b%b exp 11", busy_a, busy_b);
        else n_pass++;
        idle(); link_we = 1; link_data = 32'h7; pend_set = 1; pend_addr = 5'd31; cycle();
        idle(); link_we = 1; link_data = 32'h8; cycle(); idle(); rt = 5'd31; #1;
        n_checks++;
        if (busy_b !== 1'b0) $display("FAIL sb_link_clear got %b exp 0", busy_b);
        else n_pass++;
        idle();
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(24, 31));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            rd_en     = $urandom_range(0, 1) == 1;
            we        = $urandom_range(0, 2) != 0;
            link_we   = $urandom_range(0, 3) == 0;
            pend_set  = $urandom_range(0, 2) == 0;
            rs        = pick_addr();
            rt        = pick_addr();
            rd        = pick_addr();
            pend_addr = pick_addr();
            i_data    = $urandom;
            link_data = $urandom;
            #1;
            n_checks++;
            if (busy_a !== m_pend[rs] || busy_b !== m_pend[rt])
                $display("FAIL rand_busy n=%0d got %b%b exp %b%b", n, busy_a, busy_b,
                         m_pend[rs], m_pend[rt]);
            else n_pass++;
            cycle();
            n_checks++;
            if (out_data_a !== m_a || out_data_b !== m_b)
                $display("FAIL rand_out n=%0d got %h/%h exp %h/%h", n, out_data_a, out_data_b,
                         m_a, m_b);
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        cycle();
        cycle();
        idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_link();
        test_scoreboard();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
